// File: rtl/stream_uart_tx_pkg.sv
// stream_uart_tx_pkg: shared stream width, FSM state encoding and baud divisor arithmetic
package stream_uart_tx_pkg;
  localparam int STREAM_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction
endpackage

// File: rtl/stream_uart_tx_if.sv
// stream_uart_tx_if: 32-bit stb/ack stream
//   data  word, [7:0] carries the byte to send
//   stb   producer strobe, held until ack is seen
//   ack   consumer ready; a word moves on any edge with stb && ack
interface stream_uart_tx_if;
  import stream_uart_tx_pkg::*;
  logic [STREAM_WIDTH-1:0] data;
  logic stb;
  logic ack;
  modport master(output data, stb, input ack);
  modport slave(input data, stb, output ack);
endinterface

// File: rtl/stream_uart_tx_baud_tick.sv
// stream_uart_tx_baud_tick: bit-period counter, tick on the last clk of each period
//   clk   clock
//   rst   synchronous active-low reset
//   clr   synchronous clear, restarts the period on the next clk
//   tick  high during the last clk of a bit period
module stream_uart_tx_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/stream_uart_tx.sv
// stream_uart_tx: stb/ack stream consumer driving an 8N1 UART line (8E1 with STREAM_UART_TX_PARITY_EN)
//   clk   clock, all state on the rising edge
//   rst   synchronous active-low reset
//   in_s  stream slave; one frame per accepted word, only data[7:0] is sent
//   tx    registered UART line, idle high
//   busy  high from the accept edge until the end of the stop bit
module stream_uart_tx #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic            clk,
  input  logic            rst,
  stream_uart_tx_if.slave in_s,
  output logic            tx,
  output logic            busy
);
  import stream_uart_tx_pkg::*;
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  state_t state;
  logic ack_q;
  logic tick;
  logic accept;
  logic [7:0] byte_q;
  logic [2:0] bit_idx;
  logic unused_hi;
  assign accept = in_s.stb && ack_q;
  assign in_s.ack = ack_q;
  assign unused_hi = ^in_s.data[STREAM_WIDTH-1:8];
  // Clearing on accept lines the bit periods up with the start-bit edge.
  stream_uart_tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      ack_q   <= 1'b0;
      busy    <= 1'b0;
      byte_q  <= '0;
      bit_idx <= '0;
    end else
      case (state)
        IDLE: begin
          ack_q <= !accept;
          if (accept) begin
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            byte_q  <= in_s.data[7:0];
            bit_idx <= '0;
          end
        end
        START: if (tick) begin
          state <= DATA;
          tx    <= byte_q[0];
        end
        DATA: if (tick) begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef STREAM_UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= ^byte_q;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else tx <= byte_q[bit_idx + 3'd1];
        end
`ifdef STREAM_UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          state <= IDLE;
          busy  <= 1'b0;
          ack_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_stream_uart_tx.sv
// tb_stream_uart_tx: directed vector bench for stream_uart_tx at 10 clk per bit
module tb_stream_uart_tx;
  localparam int C = 10;
`ifdef STREAM_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic [31:0] data;
    logic [10:0] n1;
    logic [10:0] e1;
    int poke;
    int w;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, busy;
  int checks = 0;
  int errors = 0;
  int acc = 0;
  vec_t v[4];
  stream_uart_tx_if bus();
  stream_uart_tx #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100)) dut (
    .clk (clk),
    .rst (rst),
    .in_s(bus),
    .tx  (tx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst && bus.stb && bus.ack) acc <= acc + 1;

  function automatic logic [10:0] sel(input logic [10:0] n1, input logic [10:0] e1);
    return PAR ? e1 : n1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output int w);
    w = 0;
    while (!bus.ack && w < 50) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic run_frame(input string nm, input logic [31:0] d, input logic [10:0] exp,
                           input bit hold, input int poke, input int exp_w);
    int w, busy_n, ack_n, acc0;
    logic [10:0] got;
    got = '0;
    busy_n = 0;
    ack_n = 0;
    bus.data = d;
    bus.stb = 1'b1;
    wait_ack(w);
    chk({nm, " wait"}, w, exp_w);
    acc0 = acc;
    @(posedge clk);
    for (int c = 0; c < NB * C; c++) begin
      @(negedge clk);
      if (c == 0 || c == poke + 1) bus.stb = hold;
      if (c == poke) begin
        bus.stb = 1'b1;
        bus.data = 32'hFFFF_FFFF;
      end
      if (c % C == C / 2) got[c/C] = tx;
      busy_n += int'(busy);
      ack_n += int'(bus.ack);
    end
    chk({nm, " frame"}, int'(got), int'(exp));
    chk({nm, " busy cycles"}, busy_n, NB * C);
    chk({nm, " ack in frame"}, ack_n, 0);
    @(negedge clk);
    chk({nm, " one word"}, acc - acc0, 1);
    chk({nm, " idle tx/busy/ack"}, int'({tx, busy, bus.ack}), 5);
  endtask

  initial begin
    int w, lows, acc0;
    v[0] = '{32'h1234_5655, 11'h2AA, 11'h4AA, -1, 1};
    v[1] = '{32'h0000_0007, 11'h20E, 11'h60E, -1, 0};
    v[2] = '{32'h0000_0003, 11'h206, 11'h406, 33, 0};
    v[3] = '{32'hFFFF_FF0F, 11'h21E, 11'h41E, -1, 0};
    bus.stb = 1'b1;
    bus.data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset hold %0d", i), int'({tx, busy, bus.ack}), 4);
    end
    chk("no word in reset", acc, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("vec%0d", i), v[i].data, sel(v[i].n1, v[i].e1), 1'b0, v[i].poke, v[i].w);
    run_frame("b2b 00", 32'h0, sel(11'h200, 11'h400), 1'b1, 5, 0);
    run_frame("b2b FF", 32'hFF, sel(11'h3FE, 11'h5FE), 1'b0, -1, 0);
    bus.data = 32'h0F;
    bus.stb = 1'b1;
    wait_ack(w);
    chk("mid rst wait", w, 0);
    acc0 = acc;
    @(posedge clk);
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (c == 0) bus.stb = 1'b0;
    end
    chk("mid rst busy before", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst tx/busy/ack", int'({tx, busy, bus.ack}), 4);
    rst = 1'b1;
    lows = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      lows += int'(!tx) + int'(busy);
    end
    chk("no resend", lows, 0);
    chk("mid rst one word", acc - acc0, 1);
    run_frame("after rst", 32'hA6, sel(11'h34C, 11'h54C), 1'b0, -1, 0);
    acc0 = acc;
    bus.data = 32'h80;
    bus.stb = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst wins tx/busy/ack", int'({tx, busy, bus.ack}), 4);
    chk("rst wins no word", acc - acc0, 0);
    rst = 1'b1;
    run_frame("retry", 32'h80, sel(11'h300, 11'h700), 1'b0, -1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
